// File: rtl/change_dispenser_pkg.sv
// Shared coin-path constants: coin denominations and dispenser state encoding.
package change_dispenser_pkg;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_t;

endpackage

// File: rtl/change_dispenser_risingdet.sv
// Registered rising-edge detector: pulse is high for the cycle after sig is first seen high.
module risingDet (
  input  logic sys_clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic prev;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= sig;
      pulse <= sig & ~prev;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Refunds a credit value as greedy 10/5 coin eject pulses, honouring tube-empty flags
// and the ejector's ready handshake; one down-counter times both pulse and gap phases.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int CREDIT_W     = 7,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                credit_load,
  input  logic [CREDIT_W-1:0] credit_in,
  input  logic                refund_req,
  input  logic                eject_ready,
  input  logic                tube10_empty,
  input  logic                tube5_empty,
  output logic                eject_10,
  output logic                eject_5,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CREDIT_W-1:0] credit_out
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CREDIT_W-1:0] C10 = CREDIT_W'(COIN10_VAL);
  localparam logic [CREDIT_W-1:0] C5  = CREDIT_W'(COIN5_VAL);
  localparam logic [CNT_W-1:0]    PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t              state, state_nxt;
  coin_t               coin, coin_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic                err_q, err_nxt;
  logic                refund_rise;

  risingDet u_refund_rise (
    .sys_clk (sys_clk),
    .reset   (reset),
    .sig     (refund_req),
    .pulse   (refund_rise)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      coin   <= COIN_5;
      cnt    <= '0;
      credit <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      coin   <= coin_nxt;
      cnt    <= cnt_nxt;
      credit <= credit_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    coin_nxt   = coin;
    cnt_nxt    = cnt;
    credit_nxt = credit;
    err_nxt    = err_q;

    case (state)
      ST_IDLE: begin
        // Load is applied before the refund edge so a same-cycle refund pays the new value.
        if (credit_load) begin
          credit_nxt = credit_in;
          err_nxt    = 1'b0;
        end
        if (refund_rise) begin
          state_nxt = ST_SEL;
        end
      end

      ST_SEL: begin
        if (credit == '0) begin
          state_nxt = ST_DONE;
        end else if (credit >= C10 && !tube10_empty) begin
          if (eject_ready) begin
            coin_nxt   = COIN_10;
            credit_nxt = credit - C10;
            cnt_nxt    = PULSE_LOAD;
            state_nxt  = ST_PULSE;
          end
        end else if (credit >= C5 && !tube5_empty) begin
          if (eject_ready) begin
            coin_nxt   = COIN_5;
            credit_nxt = credit - C5;
            cnt_nxt    = PULSE_LOAD;
            state_nxt  = ST_PULSE;
          end
        end else begin
          // Unpayable residue or empty tubes: credit stays for the display.
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      ST_PULSE: begin
        if (cnt == '0) begin
          cnt_nxt   = GAP_LOAD;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_SEL;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign eject_10   = (state == ST_PULSE) && (coin == COIN_10);
  assign eject_5    = (state == ST_PULSE) && (coin == COIN_5);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign err        = err_q;
  assign credit_out = credit;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays accumulated customer credit back out as physical coins. Sits beside `vending_machine` on the opposite side of the coin path: `vending_machine` accumulates 5/10 coins into credit, and `change_dispenser` converts a credit value back into timed 10- and 5-unit eject pulses for the coin-return mechanism. It uses the greedy coin order, honours coin-tube empty flags, and handshakes with the ejector.

## Interface
Parameters:
- `CREDIT_W`, 7: credit width, which must match the `vending_machine` sum width.
- `PULSE_CYCLES`, 4: `sys_clk` cycles that one eject pulse is held high, ≥1.
- `GAP_CYCLES`, 4: low `sys_clk` cycles after each pulse before the next coin, ≥1.

Ports:
- `sys_clk` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `credit_load` input 1: single-cycle strobe that latches `credit_in`.
- `credit_in` input `CREDIT_W`: credit to refund.
- `refund_req` input 1: level from the refund button; the block detects its rising edge internally.
- `eject_ready` input 1: the ejector can accept a coin command.
- `tube10_empty` input 1: the 10-unit coin tube is empty.
- `tube5_empty` input 1: the 5-unit coin tube is empty.
- `eject_10` output 1: drives the 10-unit coin solenoid.
- `eject_5` output 1: drives the 5-unit coin solenoid.
- `busy` output 1: a payout is in progress.
- `done` output 1: one-cycle pulse when a payout completes.
- `err` output 1: sticky fault flag; cleared by the next `credit_load` or by `reset`.
- `credit_out` output `CREDIT_W`: remaining credit, for the display path.

## Operation
- States: IDLE, SEL, PULSE, GAP, DONE.
- IDLE:
  - `credit_load` sets `credit_out` to `credit_in` and clears `err`.
  - A `refund_req` rising edge moves to SEL.
  - If `credit_load` and the refund edge arrive in the same cycle, the load is applied first and the payout uses the new value.
- SEL, evaluated in priority order:
  - `credit_out` == 0 → DONE.
  - `credit_out` ≥ 10 and not `tube10_empty` → coin = 10.
  - else `credit_out` ≥ 5 and not `tube5_empty` → coin = 5.
  - else (tubes empty, or residue 1–4) → set `err`, go to IDLE, leave `credit_out` unchanged.
  - If a coin is selected and `eject_ready`=1 → PULSE, and `credit_out` decrements by the coin value on the same edge. If `eject_ready`=0 → stay in SEL and re-evaluate every cycle.
- PULSE: the selected `eject_*` output is high for exactly `PULSE_CYCLES` cycles, then → GAP.
- GAP: both eject outputs are low for `GAP_CYCLES` cycles, then → SEL.
- DONE: `done`=1 for one cycle, then → IDLE.
- `busy`=1 in every state except IDLE.
- `credit_load` and `refund_req` edges are ignored while `busy`=1.
- Arithmetic: unsigned; subtraction happens only when `credit_out` ≥ the coin value, so it never underflows.
- At most one eject output is high in any cycle.

## Timing
- Reset values: all outputs 0, state IDLE, sticky `err` cleared.
- `reset` asserted mid-payout takes effect at the next edge: eject outputs drop immediately and the remaining credit is discarded.
- Refund edge latency: `refund_req` rises before edge N; `risingDet` pulses during cycle N; the FSM is in SEL after edge N+1.
- First coin: if `eject_ready`=1, the `eject_*` output is high from edge N+2.
- Per coin: `PULSE_CYCLES` + `GAP_CYCLES` + 1 cycles, including the SEL cycle.
- `done` is asserted one cycle after the SEL that sees zero credit.
- Tube flags and `eject_ready` are sampled only in SEL. Changes to them during PULSE or GAP do not affect the coin in flight.

## Structure
- Coin values (5, 10) and the state encoding belong in a shared constants package, used by both `vending_machine` and `change_dispenser`.
- Reuse the existing `risingDet` sub-module for the `refund_req` edge detection.
- A single down-counter is shared by the PULSE and GAP phases.

## Test plan
- Load 25, refund, `eject_ready`=1, no tubes empty → `eject_10`, `eject_10`, `eject_5`, each high for 4 cycles with 4-cycle gaps; `credit_out` goes 15, 5, 0; then `done`; `err`=0.
- Load 15, `tube10_empty`=1 → three `eject_5` pulses, then `done`.
- Load 20, both tubes empty → `err`=1, no pulses, `credit_out`=20, return to IDLE. A subsequent `credit_load` of 0 clears `err`.
- Load 10, `eject_ready` held low 10 cycles then high → no pulse during the stall; the pulse starts the cycle after `eject_ready` rises.
- Refund with credit 0 → `done` pulse only, no eject pulses. Load 23 → two 10-coins, then `err` with `credit_out`=3.
- `reset` asserted during the second PULSE of a 20 payout → next edge gives all outputs 0, IDLE, `credit_out`=0. A `credit_load` while `busy` is ignored.
